// File: rtl/param_processor.sv
// param_processor: small multi-cycle accumulator-free load/store core.
// Four-state control (FETCH, EXEC, MEM, HALT) sharing one memory port.
// Instructions are 16 bits wide and read from the low half of mem_rdata.
// The datapath, register file and memory words are DW bits wide.
module param_processor #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          halted,
  input  logic [3:0]    dbg_sel,
  output logic [DW-1:0] dbg_out
);

  // Opcode map; anything not listed here behaves as NOP.
  localparam logic [4:0] OpNop = 5'b00000;
  localparam logic [4:0] OpAdd = 5'b00001;
  localparam logic [4:0] OpSub = 5'b00010;
  localparam logic [4:0] OpAnd = 5'b00011;
  localparam logic [4:0] OpOr  = 5'b00100;
  localparam logic [4:0] OpXor = 5'b00101;
  localparam logic [4:0] OpNot = 5'b00110;
  localparam logic [4:0] OpMov = 5'b00111;
  localparam logic [4:0] OpLdr = 5'b01000;
  localparam logic [4:0] OpStr = 5'b01001;
  localparam logic [4:0] OpJmp = 5'b01010;
  localparam logic [4:0] OpJz  = 5'b01011;
  localparam logic [4:0] OpJc  = 5'b01100;
  localparam logic [4:0] OpHlt = 5'b11111;

  // Encodings double as the state code visible on the debug port.
  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StMem   = 2'd2,
    StHalt  = 2'd3
  } state_e;

  state_e        r_state;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic [DW-1:0] r_regs [8];
  logic          r_z;
  logic          r_c;

  // Instruction fields decoded from the held IR.
  logic [4:0]    w_op;
  logic [2:0]    w_rd;
  logic [2:0]    w_ra;
  logic [2:0]    w_rb;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_d;

  assign w_op   = r_ir[15:11];
  assign w_rd   = r_ir[8:6];
  assign w_ra   = r_ir[5:3];
  assign w_rb   = r_ir[2:0];
  assign w_addr = r_ir[AW-1:0];
  assign w_a    = r_regs[w_ra];
  assign w_b    = r_regs[w_rb];
  assign w_d    = r_regs[w_rd];

  logic          w_alu_en;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_c;
  logic          w_alu_z;
  logic          w_br_taken;

  // ALU: result and carry/borrow for the current IR; w_alu_en marks flag-writing ops.
  always_comb begin
    w_alu_en  = 1'b1;
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (w_op)
      OpAdd:   {w_alu_c, w_alu_res} = {1'b0, w_a} + {1'b0, w_b};
      // The extra top bit of the widened difference is the borrow.
      OpSub:   {w_alu_c, w_alu_res} = {1'b0, w_a} - {1'b0, w_b};
      OpAnd:   w_alu_res = w_a & w_b;
      OpOr:    w_alu_res = w_a | w_b;
      OpXor:   w_alu_res = w_a ^ w_b;
      OpNot:   w_alu_res = ~w_a;
      OpMov:   w_alu_res = w_a;
      default: w_alu_en  = 1'b0;
    endcase
  end

  assign w_alu_z    = (w_alu_res == '0);
  assign w_br_taken = (w_op == OpJmp) || ((w_op == OpJz) && r_z) || ((w_op == OpJc) && r_c);

  // Bus outputs decode straight from state so reset silences them without waiting for an edge.
  assign mem_req   = !rst && ((r_state == StFetch) || (r_state == StMem));
  assign mem_we    = mem_req && (r_state == StMem) && (w_op == OpStr);
  assign mem_addr  = (r_state == StMem) ? w_addr : r_pc;
  assign mem_wdata = w_d;
  assign halted    = (r_state == StHalt);

  // Control FSM plus all architectural state; nothing moves unless step is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StFetch;
      r_pc    <= '0;
      r_ir    <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else if (step) begin
      unique case (r_state)
        StFetch: begin
          if (mem_ack) begin
            r_ir    <= mem_rdata[15:0];
            r_pc    <= r_pc + AW'(1);
            r_state <= StExec;
          end
        end
        StExec: begin
          if (w_alu_en) begin
            r_regs[w_rd] <= w_alu_res;
            r_z          <= w_alu_z;
            r_c          <= w_alu_c;
            r_state      <= StFetch;
          end else begin
            case (w_op)
              OpJmp, OpJz, OpJc: begin
                if (w_br_taken) begin
                  r_pc <= w_addr;
                end
                r_state <= StFetch;
              end
              OpLdr, OpStr: r_state <= StMem;
              OpHlt:        r_state <= StHalt;
              default:      r_state <= StFetch;
            endcase
          end
        end
        StMem: begin
          if (mem_ack) begin
            if (w_op == OpLdr) begin
              r_regs[w_rd] <= mem_rdata;
            end
            r_state <= StFetch;
          end
        end
        StHalt: begin
          // Only reset leaves HALT.
          r_state <= StHalt;
        end
      endcase
    end
  end

  // Debug mux; narrower sources are zero-extended to DW.
  always_comb begin
    dbg_out = '0;
    case (dbg_sel)
      4'd0:    dbg_out = DW'(r_pc);
      4'd1:    dbg_out = DW'(mem_addr);
      4'd2:    dbg_out = mem_rdata;
      4'd3:    dbg_out = w_a;
      4'd4:    dbg_out = w_b;
      4'd5:    dbg_out = DW'(r_ir);
      4'd6:    dbg_out = DW'({r_z, r_c});
      4'd7:    dbg_out = DW'(r_state);
      4'd8:    dbg_out = w_d;
      default: dbg_out = '0;
    endcase
  end

endmodule

// File: tb/tb_param_processor.sv
// Bench for param_processor: an instruction-level model drives the memory
// side cycle by cycle and checks bus activity and architectural state.
module tb_param_processor;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int MW = 1 << AW;

  localparam logic [4:0] OpAdd = 5'd1;
  localparam logic [4:0] OpLdr = 5'd8;
  localparam logic [4:0] OpStr = 5'd9;
  localparam logic [4:0] OpJmp = 5'd10;
  localparam logic [4:0] OpJc  = 5'd12;
  localparam logic [4:0] OpHlt = 5'd31;

  logic          clk = 1'b0;
  logic          rst;
  logic          step;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          halted;
  logic [3:0]    dbg_sel;
  logic [DW-1:0] dbg_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: memory, registers, PC, last IR, flags, halt.
  logic [15:0]   m_mem [MW];
  logic [15:0]   m_r [8];
  logic [AW-1:0] m_pc;
  logic [15:0]   m_ir;
  logic          m_z;
  logic          m_c;
  logic          m_halt;

  always #20 clk = ~clk;

  param_processor #(.DW(DW), .AW(AW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted),
    .dbg_sel   (dbg_sel),
    .dbg_out   (dbg_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [4:0] op, input int rd, input int ra,
                                      input int rb);
    return {op, 2'b00, 3'(rd), 3'(ra), 3'(rb)};
  endfunction

  function automatic logic [15:0] enc_a(input logic [4:0] op, input int rd, input int addr);
    return {op, 2'b00, 3'(rd), 6'(addr)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic a, input logic [DW-1:0] d);
    step      = s;
    mem_ack   = a;
    mem_rdata = d;
    #1;
  endtask

  task automatic rd_dbg(input logic [3:0] s, output logic [DW-1:0] v);
    dbg_sel = s;
    #1;
    v = dbg_out;
  endtask

  task automatic model_reset();
    m_pc   = '0;
    m_ir   = '0;
    m_z    = 1'b0;
    m_c    = 1'b0;
    m_halt = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
  endtask

  // Architectural state at an instruction boundary.
  task automatic post_check(input string tag);
    logic [DW-1:0] v;
    rd_dbg(4'd0, v); check_eq({tag, " pc"}, 32'(v), 32'(m_pc));
    rd_dbg(4'd5, v); check_eq({tag, " ir"}, 32'(v), 32'(m_ir));
    rd_dbg(4'd6, v); check_eq({tag, " zc"}, 32'(v), 32'({m_z, m_c}));
    rd_dbg(4'd7, v); check_eq({tag, " state"}, 32'(v), m_halt ? 32'd3 : 32'd0);
    rd_dbg(4'd3, v); check_eq({tag, " reg_ra"}, 32'(v), 32'(m_r[m_ir[5:3]]));
    rd_dbg(4'd4, v); check_eq({tag, " reg_rb"}, 32'(v), 32'(m_r[m_ir[2:0]]));
    rd_dbg(4'd8, v); check_eq({tag, " reg_rd"}, 32'(v), 32'(m_r[m_ir[8:6]]));
    check_eq({tag, " halted"}, 32'(halted), 32'(m_halt));
    check_eq({tag, " req"}, 32'(mem_req), 32'(!m_halt));
    if (!m_halt) check_eq({tag, " addr"}, 32'(mem_addr), 32'(m_pc));
  endtask

  task automatic do_reset();
    logic [DW-1:0] v;
    rst     = 1'b1;
    step    = 1'b1;
    mem_ack = 1'b0;
    #1;
    check_eq("rst req", 32'(mem_req), 32'd0);
    check_eq("rst we", 32'(mem_we), 32'd0);
    rd_dbg(4'd0, v); check_eq("rst pc", 32'(v), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    post_check("reset");
  endtask

  // Run one instruction: df fetch wait cycles, ns step-low stalls with ack
  // high, dm memory-phase wait cycles; rst_mem aborts the MEM phase.
  task automatic exec_instr(input int df, input int ns, input int dm, input bit rst_mem);
    logic [15:0]   ins;
    logic [4:0]    op;
    logic [2:0]    rd;
    logic [AW-1:0] ad;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [16:0]   s;
    logic [15:0]   res;
    logic          c;
    logic          alu;
    logic [DW-1:0] v;
    if (m_halt) begin
      drive(1'b1, 1'b0, 16'($urandom));
      check_eq("halt req", 32'(mem_req), 32'd0);
      check_eq("halt we", 32'(mem_we), 32'd0);
      tick();
      post_check("halt");
      return;
    end
    ins = m_mem[m_pc];
    for (int k = 0; k < df; k++) begin
      drive(1'b1, 1'b0, 16'($urandom));
      check_eq("fetch wait req", 32'(mem_req), 32'd1);
      check_eq("fetch wait addr", 32'(mem_addr), 32'(m_pc));
      tick();
    end
    for (int k = 0; k < ns; k++) begin
      drive(1'b0, 1'b1, ins);
      tick();
      rd_dbg(4'd0, v); check_eq("stall pc", 32'(v), 32'(m_pc));
      rd_dbg(4'd5, v); check_eq("stall ir", 32'(v), 32'(m_ir));
      check_eq("stall addr", 32'(mem_addr), 32'(m_pc));
    end
    drive(1'b1, 1'b1, ins);
    check_eq("fetch req", 32'(mem_req), 32'd1);
    check_eq("fetch we", 32'(mem_we), 32'd0);
    check_eq("fetch addr", 32'(mem_addr), 32'(m_pc));
    rd_dbg(4'd2, v); check_eq("dbg rdata", 32'(v), 32'(ins));
    tick();
    m_pc = m_pc + 1'b1;
    m_ir = ins;
    op   = ins[15:11];
    rd   = ins[8:6];
    ad   = ins[AW-1:0];
    a    = m_r[ins[5:3]];
    b    = m_r[ins[2:0]];

    drive(1'b1, 1'b0, 16'($urandom));
    check_eq("exec req", 32'(mem_req), 32'd0);
    check_eq("exec we", 32'(mem_we), 32'd0);
    rd_dbg(4'd7, v); check_eq("exec state", 32'(v), 32'd1);
    tick();

    alu = 1'b1;
    res = '0;
    c   = 1'b0;
    case (op)
      5'd1: begin s = 17'(a) + 17'(b); res = s[15:0]; c = s[16]; end
      5'd2: begin res = a - b; c = (a < b); end
      5'd3: res = a & b;
      5'd4: res = a | b;
      5'd5: res = a ^ b;
      5'd6: res = ~a;
      5'd7: res = a;
      default: alu = 1'b0;
    endcase
    if (alu) begin
      m_r[rd] = res;
      m_z     = (res == 16'd0);
      m_c     = c;
    end else if (op == 5'd10 || (op == 5'd11 && m_z) || (op == 5'd12 && m_c)) begin
      m_pc = ad;
    end else if (op == OpHlt) begin
      m_halt = 1'b1;
    end else if (op == OpLdr || op == OpStr) begin
      if (rst_mem) begin
        drive(1'b1, 1'b0, 16'($urandom));
        check_eq("mem we before rst", 32'(mem_we), 32'(op == OpStr));
        rst = 1'b1;
        #1;
        check_eq("rst mem we", 32'(mem_we), 32'd0);
        check_eq("rst mem req", 32'(mem_req), 32'd0);
        rd_dbg(4'd7, v); check_eq("rst mem state", 32'(v), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        post_check("after rst");
        return;
      end
      for (int k = 0; k < dm; k++) begin
        drive(1'b1, 1'b0, 16'($urandom));
        check_eq("mem wait req", 32'(mem_req), 32'd1);
        check_eq("mem wait we", 32'(mem_we), 32'(op == OpStr));
        check_eq("mem wait addr", 32'(mem_addr), 32'(ad));
        rd_dbg(4'd7, v); check_eq("mem state", 32'(v), 32'd2);
        tick();
      end
      drive(1'b1, 1'b1, m_mem[ad]);
      check_eq("mem req", 32'(mem_req), 32'd1);
      check_eq("mem we", 32'(mem_we), 32'(op == OpStr));
      check_eq("mem addr", 32'(mem_addr), 32'(ad));
      if (op == OpStr) check_eq("mem wdata", 32'(mem_wdata), 32'(m_r[rd]));
      tick();
      if (op == OpLdr) m_r[rd] = m_mem[ad];
      else             m_mem[ad] = m_r[rd];
    end
    post_check("instr");
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MW; i++) m_mem[i] = '0;
  endtask

  initial begin
    logic [DW-1:0] v;
    rst       = 1'b1;
    step      = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    dbg_sel   = '0;
    clear_mem();
    model_reset();
    tick();

    // ADD r1=r0+r0 then HLT with ack always high: halted after four cycles.
    do_reset();
    m_mem[0] = enc(OpAdd, 1, 0, 0);
    m_mem[1] = enc(OpHlt, 1, 0, 0);
    exec_instr(0, 0, 0, 1'b0);
    exec_instr(0, 0, 0, 1'b0);
    check_eq("t1 halted", 32'(halted), 32'd1);
    rd_dbg(4'd8, v); check_eq("t1 r1", 32'(v), 32'd0);
    rd_dbg(4'd6, v); check_eq("t1 zc", 32'(v), 32'd2);
    for (int i = 0; i < 3; i++) exec_instr(0, 0, 0, 1'b0);

    // LDR r2,[5] with a three-cycle memory-phase delay.
    do_reset();
    clear_mem();
    m_mem[0] = enc_a(OpLdr, 2, 5);
    m_mem[5] = 16'h00FF;
    exec_instr(0, 0, 3, 1'b0);
    rd_dbg(4'd8, v); check_eq("t2 r2", 32'(v), 32'h00FF);

    // 0xFFFF + 1 carries out and sets Z; JC then branches to 0x10.
    do_reset();
    clear_mem();
    m_mem[0]    = enc_a(OpLdr, 3, 6'h20);
    m_mem[1]    = enc_a(OpLdr, 4, 6'h21);
    m_mem[2]    = enc(OpAdd, 5, 3, 4);
    m_mem[3]    = enc_a(OpJc, 5, 6'h10);
    m_mem[6'h20] = 16'hFFFF;
    m_mem[6'h21] = 16'h0001;
    for (int i = 0; i < 4; i++) exec_instr(1, 0, 1, 1'b0);
    rd_dbg(4'd8, v); check_eq("t3 r5", 32'(v), 32'd0);
    rd_dbg(4'd6, v); check_eq("t3 zc", 32'(v), 32'd3);
    check_eq("t3 fetch addr", 32'(mem_addr), 32'h10);

    // NOP at the top address wraps the PC to zero.
    do_reset();
    clear_mem();
    m_mem[0]    = enc_a(OpJmp, 0, MW - 1);
    m_mem[MW-1] = '0;
    exec_instr(0, 0, 0, 1'b0);
    exec_instr(0, 0, 0, 1'b0);
    check_eq("t4 wrap addr", 32'(mem_addr), 32'd0);

    // Five step-low cycles during a fetch with ack high change nothing.
    do_reset();
    m_mem[0] = enc(OpAdd, 6, 0, 0);
    exec_instr(0, 5, 0, 1'b0);

    // Reset in the MEM phase of a store abandons it.
    do_reset();
    clear_mem();
    m_mem[0]     = enc_a(OpLdr, 1, 6'h31);
    m_mem[1]     = enc_a(OpStr, 1, 6'h30);
    m_mem[6'h31] = 16'h1234;
    exec_instr(0, 0, 0, 1'b0);
    exec_instr(0, 0, 0, 1'b1);
    check_eq("t6 restart addr", 32'(mem_addr), 32'd0);

    // Random programs with random wait states and stalls.
    do_reset();
    for (int i = 0; i < MW; i++) begin
      m_mem[i]        = 16'($urandom);
      m_mem[i][15:11] = 5'($urandom_range(0, 15));
    end
    for (int n = 0; n < 400; n++) begin
      if (m_halt) do_reset();
      exec_instr(int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0) ? 2 : 0,
                 int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
